log2_seq: RTL

Parametrised, multi-cycle base-2 logarithm unit with valid/ready handshakes on both sides. Computes floor or ceil log2 of any unsigned WIDTH-bit value and flags zero and exact powers of two. It supersedes the 8-bit one-hot-only combinational encoder. It sits between datapath producers (size/stride fields, FIFO depths, shift-amount generators) and consumers that need a shift count.

---
 rtl/log2_seq.sv | 111 +++++++++++
 1 files changed

// File: rtl/log2_seq.sv
// rtl/log2_seq.sv - multi-cycle floor/ceil log2 with zero and power-of-two flags
module log2_seq #(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_value,
  input  logic                         in_ceil,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(WIDTH+1)-1:0]   out_power,
  output logic                         out_exact,
  output logic                         out_zero
);

  localparam int S  = $clog2(WIDTH);
  localparam int PW = $clog2(WIDTH + 1);
  localparam int P  = 1 << S;
  localparam int SW = (S > 1) ? $clog2(S) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    r_state;
  logic [P-1:0]  r_val;
  logic [PW-1:0] r_acc;
  logic [SW-1:0] r_step;
  logic          r_ceil;
  logic          r_exact;
  logic          r_zero;
  logic [PW-1:0] r_power;
  logic          r_out_exact;
  logic          r_out_zero;

  logic [PW-1:0] w_sh;
  logic [P-1:0]  w_val_sh;
  logic          w_take;
  logic [PW-1:0] w_acc_next;
  logic [P-1:0]  w_val_next;
  logic [PW-1:0] w_result;
  logic          w_in_exact;
  logic          w_accept;
  logic          w_last;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_power = r_power;
  assign out_exact = r_out_exact;
  assign out_zero  = r_out_zero;

  assign w_accept   = in_valid && in_ready;
  assign w_last     = (r_step == '0);
  assign w_in_exact = (in_value != '0) && ((in_value & (in_value - WIDTH'(1))) == '0);

  // One binary-search step: shift by 2^k if anything survives above it.
  assign w_sh       = PW'(1) << r_step;
  assign w_val_sh   = r_val >> w_sh;
  assign w_take     = |w_val_sh;
  assign w_acc_next = w_take ? (r_acc + w_sh) : r_acc;
  assign w_val_next = w_take ? w_val_sh : r_val;
  assign w_result   = w_acc_next + PW'(r_ceil && !r_exact && !r_zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_val       <= '0;
      r_acc       <= '0;
      r_step      <= '0;
      r_ceil      <= 1'b0;
      r_exact     <= 1'b0;
      r_zero      <= 1'b0;
      r_power     <= '0;
      r_out_exact <= 1'b0;
      r_out_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= CALC;
            r_val   <= P'(in_value);
            r_acc   <= '0;
            r_step  <= SW'(S - 1);
            r_ceil  <= in_ceil;
            r_exact <= w_in_exact;
            r_zero  <= (in_value == '0);
          end
        end
        CALC: begin
          r_val <= w_val_next;
          r_acc <= w_acc_next;
          if (w_last) begin
            r_state     <= DONE;
            r_power     <= w_result;
            r_out_exact <= r_exact;
            r_out_zero  <= r_zero;
          end else begin
            r_step <= r_step - SW'(1);
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
